// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, req/gnt/rvalid memory reads, 2-entry buffer towards decode.
// Optional FETCH_ALIGN_CHECK_EN: misaligned redirect targets stall fetch and raise fetch_misaligned.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc_plus4,
  input  logic        instr_ready
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        fetch_misaligned
`endif
);

  logic [31:0] fetchPc;
  logic [31:0] bufInstr [2];
  logic [31:0] bufPc [2];
  logic        bufWrPtr;
  logic        bufRdPtr;
  logic [1:0]  bufCount;
  logic [31:0] pcQueue [2];
  logic        pcqWrPtr;
  logic        pcqRdPtr;
  logic [1:0]  inflight;
  logic [1:0]  dropCnt;

  logic        issueAccept;
  logic        bufWrite;
  logic        dropResp;
  logic        popFire;
  logic [2:0]  creditUsed;
  logic [1:0]  dropSum;
  logic [1:0]  dropOnRedirect;
  logic        fetchStall;
  logic [31:0] targetPc;

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalignedReg;

  always_ff @(posedge clk) begin
    if (reset) begin
      misalignedReg <= 1'b0;
    end else if (redirect) begin
      misalignedReg <= |redirect_pc[1:0];
    end
  end

  assign fetch_misaligned = misalignedReg;
  assign fetchStall       = misalignedReg;
  assign targetPc         = redirect_pc;
`else
  assign fetchStall = 1'b0;
  assign targetPc   = redirect_pc & ~32'h0000_0003;
`endif

  assign popFire  = instr_valid && instr_ready;
  assign dropResp = imem_rvalid && (dropCnt != 2'd0);
  // A response with nothing outstanding is a protocol error and is simply ignored.
  assign bufWrite = imem_rvalid && (dropCnt == 2'd0) && (inflight != 2'd0)
                    && !redirect && !reset;

  // The entry leaving the buffer this cycle frees its credit immediately, which is
  // what sustains one instruction per cycle with a single-cycle memory.
  assign creditUsed = 3'(inflight) + 3'(dropCnt) + 3'(bufCount) - 3'(popFire);

  assign imem_req    = !reset && !redirect && !fetchStall && (creditUsed < 3'd2);
  assign imem_addr   = fetchPc;
  assign issueAccept = imem_req && imem_gnt;

  // Everything still outstanding becomes stale; a response landing now is discarded too.
  assign dropSum        = dropCnt + inflight;
  assign dropOnRedirect = (imem_rvalid && (dropSum != 2'd0)) ? dropSum - 2'd1 : dropSum;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetchPc  <= RESET_PC;
      bufWrPtr <= 1'b0;
      bufRdPtr <= 1'b0;
      bufCount <= 2'd0;
      pcqWrPtr <= 1'b0;
      pcqRdPtr <= 1'b0;
      inflight <= 2'd0;
      dropCnt  <= 2'd0;
    end else if (redirect) begin
      fetchPc  <= targetPc;
      bufWrPtr <= 1'b0;
      bufRdPtr <= 1'b0;
      bufCount <= 2'd0;
      pcqWrPtr <= 1'b0;
      pcqRdPtr <= 1'b0;
      inflight <= 2'd0;
      dropCnt  <= dropOnRedirect;
    end else begin
      if (issueAccept) begin
        fetchPc  <= fetchPc + 32'd4;
        pcqWrPtr <= ~pcqWrPtr;
      end
      if (dropResp) begin
        dropCnt <= dropCnt - 2'd1;
      end
      if (bufWrite) begin
        bufWrPtr <= ~bufWrPtr;
        pcqRdPtr <= ~pcqRdPtr;
      end
      if (popFire) begin
        bufRdPtr <= ~bufRdPtr;
      end
      bufCount <= bufCount + 2'(bufWrite) - 2'(popFire);
      inflight <= inflight + 2'(issueAccept) - 2'(bufWrite);
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : gEntry
    always_ff @(posedge clk) begin
      if (issueAccept && (pcqWrPtr == 1'(gi))) begin
        pcQueue[gi] <= fetchPc;
      end
      if (bufWrite && (bufWrPtr == 1'(gi))) begin
        bufInstr[gi] <= imem_rdata;
        bufPc[gi]    <= pcQueue[pcqRdPtr];
      end
    end
  end

  assign instr_valid    = (bufCount != 2'd0);
  assign instr          = instr_valid ? bufInstr[bufRdPtr] : 32'h0000_0013;
  assign instr_pc       = instr_valid ? bufPc[bufRdPtr] : 32'h0000_0000;
  assign instr_pc_plus4 = instr_pc + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: memory model returns ~addr, monitor checks every accepted instruction.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus4;
  logic        instr_ready;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fetch_misaligned;
`endif

  int vectors = 0;
  int miscompares = 0;
  int unsigned cyc = 0;
  int unsigned memLat = 1;

  typedef struct {
    int unsigned due;
    logic [31:0] addr;
  } memEntry_t;

  memEntry_t   memQ[$];
  memEntry_t   memE;
  int unsigned memDue;
  int unsigned lastDue = 0;
  logic [31:0] expQ[$];
  logic [31:0] expPc;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_pc_plus4 (instr_pc_plus4),
    .instr_ready    (instr_ready)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .fetch_misaligned (fetch_misaligned)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // In-order memory: word at addr is ~addr, response memLat cycles after acceptance.
  always @(negedge clk) begin
    if (reset) begin
      memQ.delete();
      lastDue     = 0;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end else begin
      imem_rvalid = 1'b0;
      if (memQ.size() != 0 && memQ[0].due <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = ~memQ[0].addr;
        void'(memQ.pop_front());
      end
      if (imem_req && imem_gnt) begin
        memDue = cyc + memLat;
        if (memDue <= lastDue) memDue = lastDue + 1;
        memE.due  = memDue;
        memE.addr = imem_addr;
        memQ.push_back(memE);
        lastDue = memDue;
      end
    end
  end

  // Handshakes in a redirect cycle are squashed by the flush, so they are not consumed.
  always @(negedge clk) begin
    if (!reset && !redirect && instr_valid && instr_ready) begin
      if (expQ.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_instr: got pc %h, required no instruction", instr_pc);
      end else begin
        expPc = expQ.pop_front();
        $display("txn pc=%h instr=%h pc_plus4=%h", instr_pc, instr, instr_pc_plus4);
        check("instr_pc", instr_pc, expPc);
        check("instr", instr, ~expPc);
        check("instr_pc_plus4", instr_pc_plus4, expPc + 32'd4);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (expQ.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_left", 32'(expQ.size()), 32'd0);
    expQ.delete();
    instr_ready = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    imem_gnt    = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    instr_ready = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;

    repeat (3) tick();
    @(negedge clk);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'h0000_0013);
    check("rst_instr_pc", instr_pc, 32'h0);

    // Free run from RESET_PC with single-cycle memory.
    tick();
    reset = 1'b0;
    for (int p = 0; p <= 32'h1C; p += 4) expQ.push_back(32'(p));
    @(negedge clk);
    check("c0_imem_req", 32'(imem_req), 32'd1);
    check("c0_imem_addr", imem_addr, 32'h0);
    check("c0_instr_valid", 32'(instr_valid), 32'd0);
    tick();
    @(negedge clk);
    check("c1_instr_valid", 32'(instr_valid), 32'd0);
    check("c1_imem_addr", imem_addr, 32'h4);
    tick();
    @(negedge clk);
    check("c2_instr_valid", 32'(instr_valid), 32'd1);
    tick();
    @(negedge clk);
    check("c3_instr_valid", 32'(instr_valid), 32'd1);

    // Backpressure: head pc 0x8 held, no requests while buffer is full.
    tick();
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_imem_req", 32'(imem_req), 32'd0);
      check("bp_instr_valid", 32'(instr_valid), 32'd1);
      check("bp_instr_pc", instr_pc, 32'h8);
      check("bp_instr", instr, ~32'h8);
      tick();
    end
    instr_ready = 1'b1;
    drain(30);

    // Redirect with two reads in flight on a 3-cycle memory.
    memLat = 3;
    repeat (4) tick();
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    @(negedge clk);
    check("rd1_imem_req", 32'(imem_req), 32'd0);
    tick();
    redirect = 1'b0;
    @(negedge clk);
    check("rd1_next_valid", 32'(instr_valid), 32'd0);
    check("rd1_next_req", 32'(imem_req), 32'd1);
    check("rd1_next_addr", imem_addr, 32'h40);
    tick();
    @(negedge clk);
    check("rd1_second_addr", imem_addr, 32'h44);
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    instr_ready = 1'b1;
    expQ.push_back(32'h100);
    expQ.push_back(32'h104);
    expQ.push_back(32'h108);
    tick();
    redirect = 1'b0;
    drain(40);

    // Redirect coinciding with rvalid and a pop, target at the top of the address space.
    memLat = 1;
    repeat (6) tick();
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    instr_ready = 1'b1;
    expQ.push_back(32'h200);
    expQ.push_back(32'h204);
    tick();
    redirect = 1'b0;
    repeat (4) tick();
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    expQ.push_back(32'hFFFF_FFFC);
    expQ.push_back(32'h0);
    expQ.push_back(32'h4);
    @(negedge clk);
    check("rd2_imem_req", 32'(imem_req), 32'd0);
    check("rd2_pop_valid", 32'(instr_valid), 32'd1);
    tick();
    redirect = 1'b0;
    @(negedge clk);
    check("rd2_flushed_valid", 32'(instr_valid), 32'd0);
    check("rd2_flushed_instr", instr, 32'h0000_0013);
    check("rd2_req", 32'(imem_req), 32'd1);
    check("rd2_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    @(negedge clk);
    check("wrap_valid_r2", 32'(instr_valid), 32'd0);
    check("wrap_addr", imem_addr, 32'h0);
    tick();
    @(negedge clk);
    check("wrap_valid_r3", 32'(instr_valid), 32'd1);
    check("wrap_plus4", instr_pc_plus4, 32'h0);
    drain(20);

    // Misaligned redirect to 0x102.
    repeat (4) tick();
    redirect    = 1'b1;
    redirect_pc = 32'h102;
    instr_ready = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mis_flag", 32'(fetch_misaligned), 32'd1);
      check("mis_imem_req", 32'(imem_req), 32'd0);
      tick();
    end
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    expQ.push_back(32'h200);
    expQ.push_back(32'h204);
    tick();
    redirect = 1'b0;
    @(negedge clk);
    check("mis_flag_clear", 32'(fetch_misaligned), 32'd0);
    check("mis_resume_addr", imem_addr, 32'h200);
`else
    expQ.push_back(32'h100);
    expQ.push_back(32'h104);
    tick();
    redirect = 1'b0;
    @(negedge clk);
    check("mis_req", 32'(imem_req), 32'd1);
    check("mis_addr", imem_addr, 32'h100);
`endif
    tick();
    drain(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
